memory_data_queue: RTL
======================

MEMORY_DATA_QUEUE -- requirements
Module: memory_data_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data byte width.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 SHALL derive localparam PTR_W = $clog2(DEPTH) and CNT_W = PTR_W+1.
REQ-004 FSM_Signal  in  1  sole clock; all state updates on its negative edge.
REQ-005 reset_MDQ_n  in  1  asynchronous, active-low reset.
REQ-006 flush_MDQ  in  1  synchronous clear of contents.
REQ-007 load_MDQ  in  1  push IN_MDQ.
REQ-008 IN_MDQ  in  DATA_W  push data.
REQ-009 pop_MDQ  in  1  discard one head entry.
REQ-010 pop2_MDQ  in  1  discard two head entries (16-bit operand consumed).
REQ-011 OUT_MDQ  out  DATA_W  head entry (low byte).
REQ-012 OUT_MDQ_HI  out  DATA_W  entry after head (high byte).
REQ-013 OUT_WORD  out  2*DATA_W  {OUT_MDQ_HI, OUT_MDQ}, little-endian operand.
REQ-014 valid_MDQ / valid2_MDQ  out  1 each  count >= 1 / count >= 2.
REQ-015 full_MDQ / empty_MDQ  out  1 each  count == DEPTH / count == 0.
REQ-016 count_MDQ  out  CNT_W  occupied entries, 0..DEPTH.
REQ-017 ovf_err_MDQ / unf_err_MDQ  out  1 each  sticky overflow / underflow flags.

Function
REQ-018 Storage SHALL be circular: write pointer, read pointer, PTR_W bits each, wrapping DEPTH-1 -> 0.
REQ-019 Pushed data SHALL be visible on OUT_MDQ (if queue was empty) or at its position after exactly one FSM_Signal negedge.
REQ-020 OUT_MDQ SHALL be 0 when empty; OUT_MDQ_HI SHALL be 0 when count < 2; both combinational from storage and pointers.
REQ-021 Priority per edge: flush_MDQ > pop2_MDQ > pop_MDQ; push evaluated alongside the selected pop.
REQ-022 flush_MDQ SHALL zero pointers and count, drop a same-edge push, leave error flags unchanged.
REQ-023 pop2_MDQ with count >= 2 SHALL advance read pointer by 2 (mod DEPTH); with count < 2 SHALL be ignored and set unf_err_MDQ.
REQ-024 pop_MDQ with count == 0 SHALL be ignored and set unf_err_MDQ; a same-edge push is still accepted.
REQ-025 Push when full SHALL be accepted only if a valid pop/pop2 occurs on the same edge; otherwise dropped and ovf_err_MDQ set.
REQ-026 Count update SHALL be count + push_accepted - popped (0, 1 or 2); never below 0 or above DEPTH.
REQ-027 Error flags SHALL clear only on reset.

Reset
REQ-028 reset_MDQ_n low SHALL immediately clear pointers, count, storage and error flags, independent of FSM_Signal.
REQ-029 During reset: OUT_MDQ = OUT_MDQ_HI = 0, OUT_WORD = 0, empty_MDQ = 1, valid/valid2/full = 0, count_MDQ = 0.
REQ-030 Reset asserted mid-operation SHALL discard all contents; first push after release lands at entry 0.

Structure
REQ-031 Shared package/include memory_data_pkg SHALL hold default DATA_W, default DEPTH and the 6502 operand width constant (2*DATA_W).
REQ-032 One sub-module mdq_ptr (PTR_W-bit wrapping pointer, advance by 0/1/2) SHALL be instantiated for read and write pointers.

Verification
REQ-033 Reset, push 0x34, 0x12, pop2 -> after push edges OUT_WORD = 0x1234, valid2 = 1; after pop2 empty = 1, OUT_WORD = 0.
REQ-034 DEPTH=4: push 0xA0..0xA3, push 0xA4 -> full = 1, count = 4, ovf_err = 1, OUT_MDQ = 0xA0.
REQ-035 Full, push 0xB0 with pop -> count stays 4, OUT_MDQ = 0xA1, last entry 0xB0; wrap verified by draining order A2,A3,B0.
REQ-036 Count = 1, pop2 -> ignored, count = 1, unf_err = 1; empty, push 0x55 with pop -> count = 1, OUT_MDQ = 0x55.
REQ-037 Count = 3, flush with push 0x77 -> count = 0, empty = 1, error flags retained.
REQ-038 Reset pulsed between clock edges with count = 3 -> outputs zero immediately; next push 0x99 -> OUT_MDQ = 0x99, count = 1.

Source files
------------

// File: rtl/memory_data_pkg.sv
// Shared constants and types for the memory data queue: default geometry,
// the 6502 little-endian operand width, and the pointer advance encoding.
package memory_data_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 4;
    localparam int OPERAND_W      = 2 * DEFAULT_DATA_W;

    typedef enum logic [1:0] {
        ADV_NONE = 2'd0,
        ADV_ONE  = 2'd1,
        ADV_TWO  = 2'd2
    } ptr_adv_e;

endpackage

// File: rtl/mdq_ptr.sv
// Wrapping circular-buffer pointer; advances by 0, 1 or 2 per negative clock
// edge and wraps naturally at 2**PTR_W.
module mdq_ptr
    import memory_data_pkg::*;
#(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  ptr_adv_e         adv,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else begin
            ptr_d = ptr_q + PTR_W'(adv);
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/memory_data_queue.sv
// Small circular byte queue presenting the head entry and the entry after it
// as a little-endian 16-bit operand; state updates on the falling clock edge.
module memory_data_queue
    import memory_data_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                        FSM_Signal,
    input  logic                        reset_MDQ_n,
    input  logic                        flush_MDQ,
    input  logic                        load_MDQ,
    input  logic [DATA_W-1:0]           IN_MDQ,
    input  logic                        pop_MDQ,
    input  logic                        pop2_MDQ,
    output logic [DATA_W-1:0]           OUT_MDQ,
    output logic [DATA_W-1:0]           OUT_MDQ_HI,
    output logic [2*DATA_W-1:0]         OUT_WORD,
    output logic                        valid_MDQ,
    output logic                        valid2_MDQ,
    output logic                        full_MDQ,
    output logic                        empty_MDQ,
    output logic [$clog2(DEPTH):0]      count_MDQ,
    output logic                        ovf_err_MDQ,
    output logic                        unf_err_MDQ
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nx;
    ptr_adv_e          rd_adv, wr_adv;

    logic              has_one, has_two, is_full;
    logic              do_pop, do_pop2, push_acc;
    logic [1:0]        n_pop;

    assign has_one = (count_q >= CNT_W'(1));
    assign has_two = (count_q >= CNT_W'(2));
    assign is_full = (count_q == CNT_W'(DEPTH));

    // Requests are single-edge strobes with no ready back-pressure: a request
    // that cannot be honoured is dropped and latched into a sticky error flag.
    // Pop2 outranks pop even when pop2 itself is rejected for lack of data.
    always_comb begin
        do_pop2 = !flush_MDQ && pop2_MDQ && has_two;
        do_pop  = !flush_MDQ && !pop2_MDQ && pop_MDQ && has_one;
        n_pop   = do_pop2 ? 2'd2 : (do_pop ? 2'd1 : 2'd0);
        // A full queue can still take a push when an entry leaves on the same edge.
        push_acc = !flush_MDQ && load_MDQ && (!is_full || (n_pop != 2'd0));

        rd_adv = do_pop2 ? ADV_TWO : (do_pop ? ADV_ONE : ADV_NONE);
        wr_adv = push_acc ? ADV_ONE : ADV_NONE;

        mem_d = mem_q;
        if (push_acc) begin
            mem_d[wr_ptr] = IN_MDQ;
        end

        count_d = count_q;
        if (flush_MDQ) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push_acc) - CNT_W'(n_pop);
        end

        ovf_d = ovf_q;
        unf_d = unf_q;
        if (!flush_MDQ) begin
            if (load_MDQ && !push_acc) begin
                ovf_d = 1'b1;
            end
            if ((pop2_MDQ && !has_two) || (!pop2_MDQ && pop_MDQ && !has_one)) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(negedge FSM_Signal or negedge reset_MDQ_n) begin
        if (!reset_MDQ_n) begin
            mem_q   <= '{default: '0};
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    mdq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (FSM_Signal),
        .rst_n (reset_MDQ_n),
        .clr   (flush_MDQ),
        .adv   (rd_adv),
        .ptr   (rd_ptr)
    );

    mdq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (FSM_Signal),
        .rst_n (reset_MDQ_n),
        .clr   (flush_MDQ),
        .adv   (wr_adv),
        .ptr   (wr_ptr)
    );

    assign rd_ptr_nx = rd_ptr + PTR_W'(1);

    assign OUT_MDQ     = has_one ? mem_q[rd_ptr]    : '0;
    assign OUT_MDQ_HI  = has_two ? mem_q[rd_ptr_nx] : '0;
    assign OUT_WORD    = {OUT_MDQ_HI, OUT_MDQ};
    assign valid_MDQ   = has_one;
    assign valid2_MDQ  = has_two;
    assign full_MDQ    = is_full;
    assign empty_MDQ   = !has_one;
    assign count_MDQ   = count_q;
    assign ovf_err_MDQ = ovf_q;
    assign unf_err_MDQ = unf_q;

endmodule
